mult_share_ctrl: RTL and testbench
==================================

MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 1, giving the multiplier cell pipeline depth in M_en-qualified cycles (1..4).
REQ-002 SHALL have parameter W, default 32, giving the operand and result width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 r0_valid, r1_valid  input  1 each  requester N presents an operand pair.
REQ-006 r0_src1, r0_src2, r1_src1, r1_src2  input  W each  requester N operands.
REQ-007 r0_ready, r1_ready  output  1 each  operands accepted when valid and ready are both high.
REQ-008 r0_done, r1_done  output  1 each  one-cycle pulse; result is valid for requester N.
REQ-009 result  output  W  low W bits of src1*src2, valid while any done is high.
REQ-010 E_src1, E_src2  output  W each  operands driven to the shared multiplier cell.
REQ-011 M_en  output  1  cell pipeline enable.
REQ-012 M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3  input  W each  partial products lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2).

Function
REQ-013 FSM states: IDLE, ISSUE, COMBINE, DONE.
REQ-014 IDLE: ready SHALL be high only for the arbitration winner, and only when that requester's valid is high; both readys SHALL be low in every other state.
REQ-015 Arbitration SHALL be 2-way round-robin: on simultaneous valids, grant the requester not granted last; the pointer SHALL favour r0 after reset.
REQ-016 On accept (IDLE, valid&ready), SHALL latch operands and owner, then go to ISSUE.
REQ-017 ISSUE: E_src1/E_src2 = latched operands; M_en=1 for exactly LATENCY cycles (down-counter); then COMBINE.
REQ-018 M_en SHALL be 0 in IDLE, COMBINE and DONE; E_src1/E_src2 SHALL hold the last latched values outside ISSUE.
REQ-019 COMBINE: result register <= p1 + (p2[15:0]<<16) + (p3[15:0]<<16), truncated modulo 2^W with carries discarded; next state DONE.
REQ-020 DONE: owner's done=1 for one cycle, the other done=0; then IDLE. The round-robin pointer SHALL update to the owner.
REQ-021 Latency: with accept at cycle T, done SHALL assert at cycle T+LATENCY+2; result SHALL hold until the next COMBINE.
REQ-022 Throughput: one operation per LATENCY+3 cycles; back-to-back accept SHALL be permitted in the IDLE cycle that follows DONE.
REQ-023 A valid that drops before ready is ignored; no operation is queued and no done is issued for it.
REQ-024 Operands change or valid deassertion after accept SHALL NOT affect the in-flight operation.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE, readys 0, dones 0, M_en 0, E_src1/E_src2 0, result 0, counter 0, pointer to r0.
REQ-026 Reset mid-operation SHALL abort it; no done SHALL be issued for the aborted operation after release.
REQ-027 The first accept SHALL be possible in the first cycle after reset_n deasserts.

Structure
REQ-028 Package mult_share_pkg SHALL hold the FSM state enum, the W default, the half-width constant (16) and the LATENCY counter width.
REQ-029 Sub-module mult_share_rr_arb (2-way round-robin: req[1:0], update, owner -> gnt[1:0]) SHALL be instantiated once.
REQ-030 The multiplier cell SHALL be instantiated outside this block; this block SHALL only drive and consume its ports.

Verification
REQ-031 r0 only: src1=0x0001_0003, src2=0x0002_0005 (accept at T) -> r0_done at T+3, result=0x000B_000F, M_en high only in cycle T+1.
REQ-032 r1: 0xFFFF_FFFF*0xFFFF_FFFF -> result=0x0000_0001 (wrap-around); r0_done stays 0.
REQ-033 Both valid continuously, 4 ops -> grants r0,r1,r0,r1; done every 4 cycles; results match a reference model.
REQ-034 reset_n pulsed low during ISSUE -> all outputs 0 immediately; no done after release; next accept goes to r0.
REQ-035 LATENCY=3, src1=7, src2=9 -> M_en high 3 cycles; done at T+5; result=63.
REQ-036 r0 changes operands the cycle after accept -> result reflects the original operands.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared-multiplier controller.
// Holds the FSM encoding, default width, half-width split and LATENCY counter sizing.
package mult_share_pkg;

  localparam int W_DEFAULT = 32;
  localparam int HALF_W    = 16;
  localparam int LAT_MAX   = 4;
  localparam int CNT_W     = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COMBINE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mult_share_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
// The priority pointer favours requester 0 out of reset.
module mult_share_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] gnt
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic r_prio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= 1'b0;
    end else if (update) begin
      r_prio <= ~owner;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = r_prio ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one external pipelined multiplier cell between two requesters.
// Each operation runs IDLE -> ISSUE (LATENCY cycles) -> COMBINE -> DONE.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int W       = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         r0_valid,
  input  logic [W-1:0] r0_src1,
  input  logic [W-1:0] r0_src2,
  input  logic         r1_valid,
  input  logic [W-1:0] r1_src1,
  input  logic [W-1:0] r1_src2,
  output logic         r0_ready,
  output logic         r1_ready,
  output logic         r0_done,
  output logic         r1_done,
  output logic [W-1:0] result,
  output logic [W-1:0] E_src1,
  output logic [W-1:0] E_src2,
  output logic         M_en,
  input  logic [W-1:0] M_mul_cell_p1,
  input  logic [W-1:0] M_mul_cell_p2,
  input  logic [W-1:0] M_mul_cell_p3
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_src1;
  logic [W-1:0]     r_src2;
  logic [W-1:0]     r_result;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic [1:0]       w_win;
  logic [1:0]       w_ready;
  logic [1:0]       w_done;
  logic [W-1:0]     w_src1 [2];
  logic [W-1:0]     w_src2 [2];
  logic             w_idle;
  logic             w_accept;
  logic             w_sel;
  logic [W-1:0]     w_cross;
  logic [W-1:0]     w_sum;
  logic             w_unused;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_req     = {r1_valid, r0_valid};
  assign w_src1[0] = r0_src1;
  assign w_src2[0] = r0_src2;
  assign w_src1[1] = r1_src1;
  assign w_src2[1] = r1_src2;

  mult_share_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .update  (r_state == ST_DONE),
    .owner   (r_owner),
    .gnt     (w_gnt)
  );

  // Ready is also masked by reset so it reads low while reset_n is held.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_win[gi]   = w_idle && w_gnt[gi];
      assign w_ready[gi] = w_win[gi] && reset_n;
      assign w_done[gi]  = (r_state == ST_DONE) && (r_owner == 1'(gi));
    end
  endgenerate

  assign w_accept = |w_win;
  assign w_sel    = w_gnt[1];

  assign r0_ready = w_ready[0];
  assign r1_ready = w_ready[1];
  assign r0_done  = w_done[0];
  assign r1_done  = w_done[1];
  assign result   = r_result;
  assign E_src1   = r_src1;
  assign E_src2   = r_src2;
  assign M_en     = (r_state == ST_ISSUE);

  // The two cross terms only contribute their low half above bit HALF_W.
  assign w_cross  = W'(M_mul_cell_p2[HALF_W-1:0]) + W'(M_mul_cell_p3[HALF_W-1:0]);
  assign w_sum    = M_mul_cell_p1 + (w_cross << HALF_W);
  assign w_unused = ^{M_mul_cell_p2[W-1:HALF_W], M_mul_cell_p3[W-1:HALF_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_next = ST_ISSUE;
      ST_ISSUE:   if (r_cnt <= CNT_W'(1)) w_state_next = ST_COMBINE;
      ST_COMBINE: w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src1   <= '0;
      r_src2   <= '0;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_src1  <= w_src1[w_sel];
        r_src2  <= w_src2[w_sel];
        r_owner <= w_sel;
        r_cnt   <= LAT_LOAD;
      end else if ((r_state == ST_ISSUE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == ST_COMBINE) begin
        r_result <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: LATENCY=1 and LATENCY=3 instances, each
// with a behavioural multiplier cell; a monitor checks every done pulse.
module tb_mult_share_ctrl;

  localparam int W = 32;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t a_q[$];
  exp_t b_q[$];

  logic         a_rst_n, a_r0_valid, a_r1_valid, a_r0_ready, a_r1_ready, a_r0_done, a_r1_done, a_men;
  logic [W-1:0] a_r0_src1, a_r0_src2, a_r1_src1, a_r1_src2, a_result, a_e1, a_e2, a_p1, a_p2, a_p3;
  logic         b_rst_n, b_r0_valid, b_r1_valid, b_r0_ready, b_r1_ready, b_r0_done, b_r1_done, b_men;
  logic [W-1:0] b_r0_src1, b_r0_src2, b_r1_src1, b_r1_src2, b_result, b_e1, b_e2, b_p1, b_p2, b_p3;
  logic [W-1:0] b_s1 [3];
  logic [W-1:0] b_s2 [3];
  logic [W-1:0] b_s3 [3];

  logic [31:0] rr_s1  [4] = '{32'h0000_0007, 32'h0001_0001, 32'hDEAD_BEEF, 32'h8000_0000};
  logic [31:0] rr_s2  [4] = '{32'h0000_0006, 32'h0001_0001, 32'h0000_0010, 32'h0000_0002};
  logic [31:0] rr_exp [4] = '{32'h0000_002A, 32'h0002_0001, 32'hEADB_EEF0, 32'h0000_0000};
  logic        rr_own [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  mult_share_ctrl #(.LATENCY(1), .W(W)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n),
    .r0_valid(a_r0_valid), .r0_src1(a_r0_src1), .r0_src2(a_r0_src2),
    .r1_valid(a_r1_valid), .r1_src1(a_r1_src1), .r1_src2(a_r1_src2),
    .r0_ready(a_r0_ready), .r1_ready(a_r1_ready), .r0_done(a_r0_done), .r1_done(a_r1_done),
    .result(a_result), .E_src1(a_e1), .E_src2(a_e2), .M_en(a_men),
    .M_mul_cell_p1(a_p1), .M_mul_cell_p2(a_p2), .M_mul_cell_p3(a_p3)
  );

  mult_share_ctrl #(.LATENCY(3), .W(W)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n),
    .r0_valid(b_r0_valid), .r0_src1(b_r0_src1), .r0_src2(b_r0_src2),
    .r1_valid(b_r1_valid), .r1_src1(b_r1_src1), .r1_src2(b_r1_src2),
    .r0_ready(b_r0_ready), .r1_ready(b_r1_ready), .r0_done(b_r0_done), .r1_done(b_r1_done),
    .result(b_result), .E_src1(b_e1), .E_src2(b_e2), .M_en(b_men),
    .M_mul_cell_p1(b_p1), .M_mul_cell_p2(b_p2), .M_mul_cell_p3(b_p3)
  );

  // Behavioural multiplier cells: partial products advance only on M_en.
  always @(posedge clk) begin
    if (a_men) begin
      a_p1 <= {16'h0, a_e1[15:0]}  * {16'h0, a_e2[15:0]};
      a_p2 <= {16'h0, a_e1[15:0]}  * {16'h0, a_e2[31:16]};
      a_p3 <= {16'h0, a_e1[31:16]} * {16'h0, a_e2[15:0]};
    end
  end

  always @(posedge clk) begin
    if (b_men) begin
      b_s1[0] <= {16'h0, b_e1[15:0]}  * {16'h0, b_e2[15:0]};
      b_s2[0] <= {16'h0, b_e1[15:0]}  * {16'h0, b_e2[31:16]};
      b_s3[0] <= {16'h0, b_e1[31:16]} * {16'h0, b_e2[15:0]};
      for (int k = 1; k < 3; k++) begin
        b_s1[k] <= b_s1[k-1];
        b_s2[k] <= b_s2[k-1];
        b_s3[k] <= b_s3[k-1];
      end
    end
  end
  assign b_p1 = b_s1[2];
  assign b_p2 = b_s2[2];
  assign b_p3 = b_s3[2];

  int a_men_cnt = 0, a_men_last = -1, b_men_cnt = 0, b_men_last = -1;
  always @(negedge clk) begin
    if (a_men) begin
      a_men_cnt  <= a_men_cnt + 1;
      a_men_last <= cyc;
    end
    if (b_men) begin
      b_men_cnt  <= b_men_cnt + 1;
      b_men_last <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every done pulse is matched against the head of its scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (a_r0_done || a_r1_done) begin
      if (a_q.size() == 0) begin
        check("a_spurious_done", {30'd0, a_r1_done, a_r0_done}, 32'd0);
      end else begin
        e = a_q.pop_front();
        $display("[%0d] A done r0=%0b r1=%0b result=0x%08h", cyc, a_r0_done, a_r1_done, a_result);
        check("a_done_owner", {30'd0, a_r1_done, a_r0_done}, e.owner ? 32'd2 : 32'd1);
        check("a_result", a_result, e.res);
        check("a_done_cycle", cyc, e.cyc);
      end
    end
    if (b_r0_done || b_r1_done) begin
      if (b_q.size() == 0) begin
        check("b_spurious_done", {30'd0, b_r1_done, b_r0_done}, 32'd0);
      end else begin
        e = b_q.pop_front();
        $display("[%0d] B done r0=%0b r1=%0b result=0x%08h", cyc, b_r0_done, b_r1_done, b_result);
        check("b_done_owner", {30'd0, b_r1_done, b_r0_done}, e.owner ? 32'd2 : 32'd1);
        check("b_result", b_result, e.res);
        check("b_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic a_issue(input logic req, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] exp_res, input bit scramble, output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = -1;
    @(negedge clk);
    if (!req) begin
      a_r0_src1 = s1; a_r0_src2 = s2; a_r0_valid = 1'b1;
    end else begin
      a_r1_src1 = s1; a_r1_src2 = s2; a_r1_valid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((!req && a_r0_ready) || (req && a_r1_ready)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("a_accept_timeout", 32'd0, 32'd1);
      a_r0_valid = 1'b0;
      a_r1_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    a_q.push_back('{req, exp_res, cyc + 3});
    $display("[%0d] A accept r%0d src1=0x%08h src2=0x%08h", cyc, req, s1, s2);
    @(negedge clk);
    a_r0_valid = 1'b0;
    a_r1_valid = 1'b0;
    if (scramble) begin
      a_r0_src1 = 32'hCAFE_F00D; a_r0_src2 = 32'h5A5A_A5A5;
      a_r1_src1 = 32'hCAFE_F00D; a_r1_src2 = 32'h5A5A_A5A5;
    end
  endtask

  task automatic drain(input bit which, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if ((which ? b_q.size() : a_q.size()) == 0) return;
    end
    check(which ? "b_drain_timeout" : "a_drain_timeout", which ? b_q.size() : a_q.size(), 32'd0);
    if (which) b_q.delete(); else a_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, m0, nacc, tprev;
    bit got, own;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_r0_valid = 1'b1; a_r1_valid = 1'b1;
    a_r0_src1 = '0; a_r0_src2 = '0; a_r1_src1 = '0; a_r1_src2 = '0;
    b_r0_valid = 1'b0; b_r1_valid = 1'b0;
    b_r0_src1 = '0; b_r0_src2 = '0; b_r1_src1 = '0; b_r1_src2 = '0;

    // Reset state with both valids asserted
    #3;
    check("rst_r0_ready", a_r0_ready, 0);
    check("rst_r1_ready", a_r1_ready, 0);
    check("rst_r0_done", a_r0_done, 0);
    check("rst_r1_done", a_r1_done, 0);
    check("rst_m_en", a_men, 0);
    check("rst_e_src1", a_e1, 0);
    check("rst_e_src2", a_e2, 0);
    check("rst_result", a_result, 0);
    repeat (2) @(negedge clk);
    a_r0_valid = 1'b0; a_r1_valid = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // r0 only, LATENCY=1
    m0 = a_men_cnt;
    a_issue(1'b0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, t);
    drain(1'b0, 20);
    check("a_men_cycles", a_men_cnt - m0, 1);
    check("a_men_cycle_pos", a_men_last, t + 1);
    check("a_e_src1_hold", a_e1, 32'h0001_0003);
    check("a_e_src2_hold", a_e2, 32'h0002_0005);

    // r1 wrap-around
    a_issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, t);
    drain(1'b0, 20);

    // Both requesters valid continuously for four operations
    @(negedge clk);
    a_r0_src1 = rr_s1[0]; a_r0_src2 = rr_s2[0];
    a_r1_src1 = rr_s1[1]; a_r1_src2 = rr_s2[1];
    a_r0_valid = 1'b1; a_r1_valid = 1'b1;
    nacc = 0; tprev = -1;
    for (int c = 0; c < 60 && nacc < 4; c++) begin
      #1;
      if (a_r0_ready || a_r1_ready) begin
        own = a_r1_ready;
        check("a_rr_grant", own, rr_own[nacc]);
        if (nacc > 0) check("a_rr_spacing", cyc - tprev, 4);
        tprev = cyc;
        a_q.push_back('{own, rr_exp[nacc], cyc + 3});
        $display("[%0d] A accept r%0d (round-robin op %0d)", cyc, own, nacc);
        @(negedge clk);
        if (nacc + 2 < 4) begin
          if (own) begin
            a_r1_src1 = rr_s1[nacc + 2]; a_r1_src2 = rr_s2[nacc + 2];
          end else begin
            a_r0_src1 = rr_s1[nacc + 2]; a_r0_src2 = rr_s2[nacc + 2];
          end
        end
        nacc++;
      end else begin
        @(negedge clk);
      end
    end
    a_r0_valid = 1'b0; a_r1_valid = 1'b0;
    if (nacc < 4) check("a_rr_accept_count", nacc, 4);
    drain(1'b0, 30);

    // Operands scrambled right after accept; a short r1 valid while busy
    a_issue(1'b0, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 1'b1, t);
    a_r1_valid = 1'b1;
    @(negedge clk);
    #1;
    check("a_busy_r1_ready", a_r1_ready, 0);
    a_r1_valid = 1'b0;
    drain(1'b0, 20);
    repeat (8) @(negedge clk);

    // Reset pulse during ISSUE (pointer currently favours r1)
    @(negedge clk);
    a_r0_src1 = 32'h0000_0003; a_r0_src2 = 32'h0000_0005; a_r0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_r0_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("a_abort_accept", got, 1);
    @(negedge clk);
    a_r0_valid = 1'b0;
    #1;
    check("a_abort_in_issue", a_men, 1);
    a_r0_valid = 1'b1; a_r1_valid = 1'b1;
    a_rst_n = 1'b0;
    #1;
    check("abort_r0_ready", a_r0_ready, 0);
    check("abort_r1_ready", a_r1_ready, 0);
    check("abort_done", {a_r1_done, a_r0_done}, 0);
    check("abort_m_en", a_men, 0);
    check("abort_e_src1", a_e1, 0);
    check("abort_e_src2", a_e2, 0);
    check("abort_result", a_result, 0);
    repeat (2) @(negedge clk);
    a_r0_src1 = 32'h0000_0100; a_r0_src2 = 32'h0000_0011;
    a_rst_n = 1'b1;
    #1;
    check("post_reset_r0_ready", a_r0_ready, 1);
    check("post_reset_r1_ready", a_r1_ready, 0);
    if (a_r0_ready) a_q.push_back('{1'b0, 32'h0000_1100, cyc + 3});
    @(negedge clk);
    a_r0_valid = 1'b0; a_r1_valid = 1'b0;
    drain(1'b0, 20);
    repeat (8) @(negedge clk);

    // LATENCY=3 instance
    @(negedge clk);
    m0 = b_men_cnt;
    b_r0_src1 = 32'd7; b_r0_src2 = 32'd9; b_r0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b_r0_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("b_accept", got, 1);
    t = cyc;
    if (got) begin
      b_q.push_back('{1'b0, 32'd63, cyc + 5});
      $display("[%0d] B accept r0 src1=7 src2=9", cyc);
    end
    @(negedge clk);
    b_r0_valid = 1'b0;
    drain(1'b1, 30);
    check("b_men_cycles", b_men_cnt - m0, 3);
    check("b_men_last", b_men_last, t + 3);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
